// File: rtl/ghr_spec_ctrl.sv
// Global branch history controller: speculative and architectural histories
// with an in-order checkpoint FIFO for mispredict/flush recovery.
// Optional gshare index hashing is enabled by defining GHR_GSHARE_EN.
module ghr_spec_ctrl #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pred_valid,
  input  logic                      pred_taken,
  input  logic [31:0]               pc_f,
  input  logic                      res_valid,
  input  logic                      res_taken,
  input  logic                      res_mispredict,
  input  logic                      flush,
  output logic [W-1:0]              spec_ghr,
  output logic [W-1:0]              arch_ghr,
  output logic [W-1:0]              pred_index,
  output logic                      fetch_stall,
  output logic                      recover,
  output logic [$clog2(DEPTH):0]    inflight,
  output logic                      err_underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    spec_q, spec_d;
  logic [W-1:0]    arch_q, arch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic [W-1:0]    fifo_q [DEPTH];

  logic            in_run;
  logic            stall;
  logic            push;
  logic            pop;
  logic            fifo_we;
  logic [W-1:0]    snap;

  // Handshake decode: what moves this cycle
  always_comb begin
    in_run  = (state_q == RUN);
    stall   = (cnt_q == CW'(DEPTH)) || !in_run;
    push    = pred_valid && !stall;
    pop     = res_valid && in_run && (cnt_q != '0);
    snap    = fifo_q[rd_ptr_q];
  end

  // Next-state and history update; flush outranks mispredict restore
  always_comb begin
    state_d  = state_q;
    spec_d   = spec_q;
    arch_d   = arch_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    fifo_we  = 1'b0;

    if (in_run) begin
      if (res_valid && (cnt_q == '0)) err_d = 1'b1;
      if (push) begin
        spec_d   = {spec_q[W-2:0], pred_taken};
        wr_ptr_d = wr_ptr_q + PW'(1);
        fifo_we  = 1'b1;
      end
      if (pop) begin
        arch_d   = {arch_q[W-2:0], res_taken};
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (flush || (pop && res_mispredict)) begin
        // Squash everything in flight; same-cycle push is discarded
        spec_d   = flush ? arch_d : {snap[W-2:0], res_taken};
        cnt_d    = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        fifo_we  = 1'b0;
        state_d  = RECOVER;
      end
    end else begin
      // Single recovery bubble; all requests ignored
      state_d = RUN;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      spec_q   <= '0;
      arch_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      spec_q   <= spec_d;
      arch_q   <= arch_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Checkpoint storage: snapshot of pre-update speculative history
  always_ff @(posedge clk) begin
    if (fifo_we && !reset) fifo_q[wr_ptr_q] <= spec_q;
  end

  // Predictor index, optionally hashed with the fetch PC
  logic unused_pc;
  assign unused_pc = ^pc_f;
`ifdef GHR_GSHARE_EN
  assign pred_index = spec_q ^ pc_f[W+1:2];
`else
  assign pred_index = spec_q;
`endif

  assign spec_ghr      = spec_q;
  assign arch_ghr      = arch_q;
  assign fetch_stall   = stall;
  assign recover       = (state_q == RECOVER);
  assign inflight      = cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ghr_spec_ctrl.sv
// Directed-vector bench for ghr_spec_ctrl (W=3, DEPTH=4).
module tb_ghr_spec_ctrl;

  localparam int unsigned W     = 3;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        pred_valid, pred_taken;
  logic [31:0] pc_f;
  logic        res_valid, res_taken, res_mispredict, flush;
  logic [2:0]  spec_ghr, arch_ghr, pred_index;
  logic        fetch_stall, recover, err_underflow;
  logic [2:0]  inflight;

  ghr_spec_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pc_f(pc_f),
    .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .flush(flush),
    .spec_ghr(spec_ghr), .arch_ghr(arch_ghr), .pred_index(pred_index),
    .fetch_stall(fetch_stall), .recover(recover), .inflight(inflight),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, pv, pt, rv, rt, rm, fl;
    logic [31:0] pc;
    logic [2:0]  e_spec, e_arch, e_inf;
    logic        e_stall, e_rec, e_err;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [2:0] exp_index(input logic [2:0] s, input logic [31:0] pc);
`ifdef GHR_GSHARE_EN
    return s ^ pc[4:2];
`else
    return s;
`endif
  endfunction

  // Drive one cycle of inputs, then check registered results after the edge
  task automatic step(input vec_t v);
    logic [2:0] e_idx;
    reset = v.rst; pred_valid = v.pv; pred_taken = v.pt; pc_f = v.pc;
    res_valid = v.rv; res_taken = v.rt; res_mispredict = v.rm; flush = v.fl;
    @(posedge clk);
    #1;
    e_idx = exp_index(v.e_spec, v.pc);
    n_vec++;
    if (spec_ghr !== v.e_spec || arch_ghr !== v.e_arch || inflight !== v.e_inf ||
        fetch_stall !== v.e_stall || recover !== v.e_rec ||
        err_underflow !== v.e_err || pred_index !== e_idx) begin
      n_miss++;
      $display("FAIL %s: got spec=%b arch=%b inf=%0d stall=%b rec=%b err=%b idx=%b, want spec=%b arch=%b inf=%0d stall=%b rec=%b err=%b idx=%b",
               v.name, spec_ghr, arch_ghr, inflight, fetch_stall, recover,
               err_underflow, pred_index, v.e_spec, v.e_arch, v.e_inf,
               v.e_stall, v.e_rec, v.e_err, e_idx);
    end
  endtask

  function automatic vec_t mk(input string nm,
                              input logic rst, pv, pt, rv, rt, rm, fl,
                              input logic [31:0] pc,
                              input logic [2:0] es, ea, ei,
                              input logic est, erc, eer);
    vec_t v;
    v.name = nm; v.rst = rst; v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt;
    v.rm = rm; v.fl = fl; v.pc = pc; v.e_spec = es; v.e_arch = ea;
    v.e_inf = ei; v.e_stall = est; v.e_rec = erc; v.e_err = eer;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    reset = 1'b1; pred_valid = 0; pred_taken = 0; pc_f = '0;
    res_valid = 0; res_taken = 0; res_mispredict = 0; flush = 0;

    //            name          rst pv pt rv rt rm fl  pc          spec    arch    inf  st rc er
    tbl.push_back(mk("reset",     1, 0, 0, 0, 0, 0, 0, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 0));
    tbl.push_back(mk("pred_T",    0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b001, 3'b000, 3'd1, 0, 0, 0));
    tbl.push_back(mk("pred_N",    0, 1, 0, 0, 0, 0, 0, 32'h0,      3'b010, 3'b000, 3'd2, 0, 0, 0));
    tbl.push_back(mk("pred_T2",   0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b101, 3'b000, 3'd3, 0, 0, 0));
    tbl.push_back(mk("res_T",     0, 0, 0, 1, 1, 0, 0, 32'h0,      3'b101, 3'b001, 3'd2, 0, 0, 0));
    tbl.push_back(mk("res_N",     0, 0, 0, 1, 0, 0, 0, 32'h0,      3'b101, 3'b010, 3'd1, 0, 0, 0));
    tbl.push_back(mk("res_T2",    0, 0, 0, 1, 1, 0, 0, 32'h0,      3'b101, 3'b101, 3'd0, 0, 0, 0));
    tbl.push_back(mk("reset2",    1, 0, 0, 0, 0, 0, 0, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 0));
    tbl.push_back(mk("mp_pT",     0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b001, 3'b000, 3'd1, 0, 0, 0));
    tbl.push_back(mk("mp_pT2",    0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b011, 3'b000, 3'd2, 0, 0, 0));
    tbl.push_back(mk("mispred",   0, 0, 0, 1, 0, 1, 0, 32'h0,      3'b000, 3'b000, 3'd0, 1, 1, 0));
    tbl.push_back(mk("rec_pred",  0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 0));
    tbl.push_back(mk("full_p1",   0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b001, 3'b000, 3'd1, 0, 0, 0));
    tbl.push_back(mk("full_p2",   0, 1, 0, 0, 0, 0, 0, 32'h0,      3'b010, 3'b000, 3'd2, 0, 0, 0));
    tbl.push_back(mk("full_p3",   0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b101, 3'b000, 3'd3, 0, 0, 0));
    tbl.push_back(mk("full_p4",   0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b011, 3'b000, 3'd4, 1, 0, 0));
    tbl.push_back(mk("full_drop", 0, 1, 0, 0, 0, 0, 0, 32'h0,      3'b011, 3'b000, 3'd4, 1, 0, 0));
    tbl.push_back(mk("full_pop",  0, 0, 0, 1, 1, 0, 0, 32'h0,      3'b011, 3'b001, 3'd3, 0, 0, 0));
    tbl.push_back(mk("reset3",    1, 0, 0, 0, 0, 0, 0, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 0));
    tbl.push_back(mk("underflow", 0, 0, 0, 1, 1, 0, 0, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 1));
    tbl.push_back(mk("fl_p1",     0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b001, 3'b000, 3'd1, 0, 0, 1));
    tbl.push_back(mk("fl_p2",     0, 1, 0, 0, 0, 0, 0, 32'h0,      3'b010, 3'b000, 3'd2, 0, 0, 1));
    tbl.push_back(mk("flush",     0, 0, 0, 0, 0, 0, 1, 32'h0,      3'b000, 3'b000, 3'd0, 1, 1, 1));
    tbl.push_back(mk("rec_ign",   0, 1, 1, 1, 1, 0, 1, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 1));
    tbl.push_back(mk("gs_p1",     0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b001, 3'b000, 3'd1, 0, 0, 1));
    tbl.push_back(mk("gs_p2",     0, 1, 0, 0, 0, 0, 0, 32'h0,      3'b010, 3'b000, 3'd2, 0, 0, 1));
    tbl.push_back(mk("gs_idx",    0, 1, 1, 0, 0, 0, 0, 32'h10,     3'b101, 3'b000, 3'd3, 0, 0, 1));
    tbl.push_back(mk("fl_poppsh", 0, 1, 1, 1, 1, 0, 1, 32'h10,     3'b001, 3'b001, 3'd0, 1, 1, 1));
    tbl.push_back(mk("fl_idle",   0, 0, 0, 0, 0, 0, 0, 32'h0,      3'b001, 3'b001, 3'd0, 0, 0, 1));
    tbl.push_back(mk("mpT_p",     0, 1, 0, 0, 0, 0, 0, 32'h0,      3'b010, 3'b001, 3'd1, 0, 0, 1));
    tbl.push_back(mk("mpT_res",   0, 0, 0, 1, 1, 1, 0, 32'h0,      3'b011, 3'b011, 3'd0, 1, 1, 1));
    tbl.push_back(mk("rst_inrec", 1, 0, 0, 1, 1, 0, 0, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 0));
    tbl.push_back(mk("rq_p",      0, 1, 1, 0, 0, 0, 0, 32'h0,      3'b001, 3'b000, 3'd1, 0, 0, 0));
    tbl.push_back(mk("rq_mp",     0, 0, 0, 1, 0, 1, 0, 32'h0,      3'b000, 3'b000, 3'd0, 1, 1, 0));
    tbl.push_back(mk("rq_resign", 0, 0, 0, 1, 1, 0, 0, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 0));
    tbl.push_back(mk("rq_uflow",  0, 0, 0, 1, 1, 0, 0, 32'h0,      3'b000, 3'b000, 3'd0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Pointer wrap: fill, pop/push across the wrap, then mispredict on a wrapped slot
    step(mk("w_rst",   1, 0, 0, 0, 0, 0, 0, 32'h0, 3'b000, 3'b000, 3'd0, 0, 0, 0));
    step(mk("w_p1",    0, 1, 1, 0, 0, 0, 0, 32'h0, 3'b001, 3'b000, 3'd1, 0, 0, 0));
    step(mk("w_p2",    0, 1, 1, 0, 0, 0, 0, 32'h0, 3'b011, 3'b000, 3'd2, 0, 0, 0));
    step(mk("w_p3",    0, 1, 1, 0, 0, 0, 0, 32'h0, 3'b111, 3'b000, 3'd3, 0, 0, 0));
    step(mk("w_p4",    0, 1, 1, 0, 0, 0, 0, 32'h0, 3'b111, 3'b000, 3'd4, 1, 0, 0));
    step(mk("w_popfl", 0, 1, 0, 1, 1, 0, 0, 32'h0, 3'b111, 3'b001, 3'd3, 0, 0, 0));
    step(mk("w_both",  0, 1, 0, 1, 1, 0, 0, 32'h0, 3'b110, 3'b011, 3'd3, 0, 0, 0));
    step(mk("w_pop2",  0, 0, 0, 1, 1, 0, 0, 32'h0, 3'b110, 3'b111, 3'd2, 0, 0, 0));
    step(mk("w_pop3",  0, 0, 0, 1, 1, 0, 0, 32'h0, 3'b110, 3'b111, 3'd1, 0, 0, 0));
    step(mk("w_mp",    0, 0, 0, 1, 0, 1, 0, 32'h0, 3'b110, 3'b110, 3'd0, 1, 1, 0));
    step(mk("w_after", 0, 0, 0, 0, 0, 0, 0, 32'h0, 3'b110, 3'b110, 3'd0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
